// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   XLEN         : PC / instruction width
//   RESET_PC_DEF : default PC after reset
//   fetch_entry_t: one buffered opcode with its PC
//   fetch_state_t: fetch control FSM states
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] p);
    return {p[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus bundle: instruction memory port, redirect input and the
// valid/ready opcode stream to decode.
//   master: the fetch unit
//   slave : the environment (memory, branch unit, decode)
interface fetch_if #(parameter int IMEM_AW = 8);
  import cpu_pkg::*;
  logic                 imem_req;
  logic [IMEM_AW-1:0]   imem_addr;
  logic [31:0]          imem_rdata;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [31:0]          inst;
  logic [XLEN-1:0]      inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a flush.
//   push/din  : write one entry
//   pop       : consume head (only while valid)
//   flush     : empty the FIFO; wins over push/pop
//   valid/dout: head entry, purely from registered state
//   count     : current occupancy (0..DEPTH)
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output logic          valid,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory, buffers returned words in a skid FIFO and
// streams them to decode over valid/ready. A redirect flushes everything
// buffered or in flight and restarts at the new PC.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_if.master (imem_*, redirect_*, inst_*)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              IMEM_AW  = 8,
  parameter int              DEPTH    = 2,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);
  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            epoch;
  // One-entry tag for the request whose data returns this cycle.
  logic            inflight;
  logic [XLEN-1:0] tag_pc;
  logic            tag_epoch;

  logic            pop, push, issue;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  fetch_entry_t    head;

  assign pop  = bus.inst_valid & bus.inst_ready;
  // Stale (pre-redirect) data is dropped; redirect also flushes this cycle.
  assign push = inflight & (tag_epoch == epoch) & ~bus.redirect_valid;

  // Occupancy once this cycle's response lands and any pop leaves; a new
  // request is only sent when its data is guaranteed a free slot.
  assign occ   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = (state == RUN) & ~bus.redirect_valid & (occ < (CW+1)'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      tag_pc    <= '0;
      tag_epoch <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_pc    <= pc;
        tag_epoch <= epoch;
        pc        <= pc + XLEN'(4);
      end
      if (bus.redirect_valid) begin
        state <= FLUSH;
        epoch <= ~epoch;
        pc    <= align_pc(bus.redirect_pc);
      end else begin
        unique case (state)
          IDLE:    state <= RUN;
          FLUSH:   state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ('{inst: bus.imem_rdata, pc: tag_pc}),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .valid (bus.inst_valid),
    .dout  (head),
    .count (count)
  );

  assign bus.inst    = head.inst;
  assign bus.inst_pc = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.IMEM_AW(8)) b ();
  fetch_if #(.IMEM_AW(8)) b2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.master));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.master));

  // Synchronous instruction memory shared by both instances.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (b.imem_req)  b.imem_rdata  <= mem[b.imem_addr];
    if (b2.imem_req) b2.imem_rdata <= mem[b2.imem_addr];
  end

  assign b2.inst_ready     = 1'b1;
  assign b2.redirect_valid = 1'b0;
  assign b2.redirect_pc    = '0;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: the delivered stream is consecutive words from the
  // last start PC; a redirect restarts it.
  logic [31:0] exp_pc, exp2_pc;
  int          ndel2;
  int          since_redir;
  logic        hold;
  logic [31:0] hold_inst, hold_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rdy, input logic rv, input logic [31:0] rpc);
    b.inst_ready     = rdy;
    b.redirect_valid = rv;
    b.redirect_pc    = rpc;
    #1;
  endtask

  task automatic fin();
    if (hold) begin
      chk("hold_valid", 32'(b.inst_valid), 1);
      chk("hold_inst", b.inst, hold_inst);
      chk("hold_pc", b.inst_pc, hold_pc);
    end
    if (since_redir == 0) begin
      chk("flush_valid", 32'(b.inst_valid), 0);
      chk("flush_req", 32'(b.imem_req), 0);
    end
    if (since_redir == 1) chk("flush2_valid", 32'(b.inst_valid), 0);
    if (b.redirect_valid) chk("redir_req", 32'(b.imem_req), 0);
    chk("fifo_bound", 32'(dut.u_fifo.count <= 2), 1);
    if (b.inst_valid && b.inst_ready) begin
      chk("pc", b.inst_pc, exp_pc);
      chk("inst", b.inst, mem[exp_pc[9:2]]);
      exp_pc = exp_pc + 32'd4;
    end
    if (b2.inst_valid) begin
      chk("pc2", b2.inst_pc, exp2_pc);
      chk("inst2", b2.inst, mem[exp2_pc[9:2]]);
      exp2_pc = exp2_pc + 32'd4;
      ndel2++;
    end
    hold      = b.inst_valid & ~b.inst_ready & ~b.redirect_valid;
    hold_inst = b.inst;
    hold_pc   = b.inst_pc;
    if (b.redirect_valid) begin
      exp_pc      = {b.redirect_pc[31:2], 2'b00};
      since_redir = -1;
    end
    @(posedge clk);
    @(negedge clk);
    if (since_redir < 100) since_redir++;
  endtask

  task automatic model_reset();
    exp_pc      = 32'h0000_0000;
    exp2_pc     = 32'hFFFF_FFF8;
    ndel2       = 0;
    since_redir = 100;
    hold        = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   32'(b.imem_req), 0);
    chk({tag, "_valid"}, 32'(b.inst_valid), 0);
    chk({tag, "_inst"},  b.inst, 0);
    chk({tag, "_pc"},    b.inst_pc, 0);
    chk({tag, "_valid2"}, 32'(b2.inst_valid), 0);
    chk({tag, "_pc2"},   b2.inst_pc, 0);
  endtask

  // Cycles 0..3 after reset release: idle, first request, then first opcode.
  task automatic startup_seq();
    drv(1, 0, 0); chk("c0_req", 32'(b.imem_req), 0); fin();
    drv(1, 0, 0); chk("c1_req", 32'(b.imem_req), 1); chk("c1_addr", 32'(b.imem_addr), 0); fin();
    drv(1, 0, 0); chk("c2_addr", 32'(b.imem_addr), 1); chk("c2_valid", 32'(b.inst_valid), 0); fin();
    drv(1, 0, 0); chk("c3_valid", 32'(b.inst_valid), 1); chk("c3_pc", b.inst_pc, 0); chk("c3_inst", b.inst, 0); fin();
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = i;
    mem[4] = 32'h0000_0033;
    b.inst_ready = 1'b0; b.redirect_valid = 1'b0; b.redirect_pc = '0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    startup_seq();

    // Steady stream: pcs 4, 8, c, then 0x10 is at the head.
    repeat (3) begin drv(1, 0, 0); fin(); end
    chk("add_pc", b.inst_pc, 32'h10);
    chk("add_inst", b.inst, 32'h0000_0033);

    // Stall 5 cycles: request stops once the FIFO is committed full.
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0);
      if (i == 4) chk("stall_req", 32'(b.imem_req), 0);
      chk("stall_inst", b.inst, 32'h0000_0033);
      fin();
    end
    repeat (4) begin drv(1, 0, 0); fin(); end

    // Redirect while stalled with a response in flight; stale data dropped.
    drv(0, 0, 0); fin();
    drv(0, 1, 32'h0000_0043); fin();
    k = 0;
    drv(1, 0, 0);
    while (!b.inst_valid && k < 10) begin fin(); drv(1, 0, 0); k++; end
    chk("redir_lat", k, 3);
    chk("redir_pc", b.inst_pc, 32'h40);
    chk("redir_inst", b.inst, 32'h10);
    fin();

    // Redirect in the same cycle as an accepted pop.
    repeat (3) begin drv(1, 0, 0); fin(); end
    drv(1, 1, 32'h0000_0100);
    chk("pop_redir_valid", 32'(b.inst_valid), 1);
    fin();
    repeat (6) begin drv(1, 0, 0); fin(); end

    // Randomized traffic against the stream model.
    for (int i = 0; i < 400; i++) begin
      drv(($urandom % 4) != 0, ($urandom % 25) == 0, $urandom);
      fin();
    end
    drv(1, 0, 0);
    repeat (8) begin fin(); drv(1, 0, 0); end

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("arst");
    model_reset();
    @(negedge clk);
    chk_reset_outs("arst_hold");
    rst_n = 1'b1;
    startup_seq();
    repeat (6) begin drv(1, 0, 0); fin(); end
    chk("wrap_cnt", 32'(ndel2 >= 3), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
